// File: rtl/if_id_fifo.sv
// IF/ID instruction queue: a DEPTH-entry FIFO between fetch and decode followed by
// a registered ID-side output stage, with valid tagging, IF backpressure and occupancy.
module if_id_fifo #(
   parameter int ADDR_W = 32,
   parameter int INST_W = 32,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [5:0]        stall,
   input  logic              flush,
   input  logic              if_valid,
   input  logic [ADDR_W-1:0] if_pc,
   input  logic [INST_W-1:0] if_inst,
   output logic              if_ready,
   output logic              id_valid,
   output logic [ADDR_W-1:0] id_pc,
   output logic [INST_W-1:0] id_inst,
   output logic [CNT_W-1:0]  count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [ADDR_W-1:0] memPc_q   [DEPTH];
   logic [INST_W-1:0] memInst_q [DEPTH];

   logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
   logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              idValid_q, idValid_d;
   logic [ADDR_W-1:0] idPc_q, idPc_d;
   logic [INST_W-1:0] idInst_q, idInst_d;

   logic push, advance, empty, pop, bypass, wrEn;
   logic unusedStall;

   assign unusedStall = ^{stall[5:3], stall[0]};

   assign if_ready = (count_q < FULL_CNT) && !flush;
   assign push     = if_valid && !stall[1] && if_ready;
   assign advance  = !stall[2];
   assign empty    = (count_q == '0);
   assign pop      = advance && !empty;
   // An instruction arriving at an empty queue while ID advances skips storage entirely.
   assign bypass   = advance && empty && push;
   assign wrEn     = push && !bypass;

   always_comb begin
      rdPtr_d   = rdPtr_q;
      wrPtr_d   = wrPtr_q;
      count_d   = count_q;
      idValid_d = idValid_q;
      idPc_d    = idPc_q;
      idInst_d  = idInst_q;
      if (flush) begin
         rdPtr_d   = '0;
         wrPtr_d   = '0;
         count_d   = '0;
         idValid_d = 1'b0;
         idPc_d    = '0;
         idInst_d  = '0;
      end else begin
         if (wrEn) wrPtr_d = wrPtr_q + 1'b1;
         if (pop)  rdPtr_d = rdPtr_q + 1'b1;
         if (wrEn && !pop)      count_d = count_q + 1'b1;
         else if (pop && !wrEn) count_d = count_q - 1'b1;
         if (advance) begin
            if (pop) begin
               idValid_d = 1'b1;
               idPc_d    = memPc_q[rdPtr_q];
               idInst_d  = memInst_q[rdPtr_q];
            end else if (bypass) begin
               idValid_d = 1'b1;
               idPc_d    = if_pc;
               idInst_d  = if_inst;
            end else begin
               idValid_d = 1'b0;
               idPc_d    = '0;
               idInst_d  = '0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdPtr_q   <= '0;
         wrPtr_q   <= '0;
         count_q   <= '0;
         idValid_q <= 1'b0;
         idPc_q    <= '0;
         idInst_q  <= '0;
      end else begin
         rdPtr_q   <= rdPtr_d;
         wrPtr_q   <= wrPtr_d;
         count_q   <= count_d;
         idValid_q <= idValid_d;
         idPc_q    <= idPc_d;
         idInst_q  <= idInst_d;
      end
   end

   // Queue storage has no reset; the pointers and count alone define its validity.
   always_ff @(posedge clk) begin
      if (wrEn) begin
         memPc_q[wrPtr_q]   <= if_pc;
         memInst_q[wrPtr_q] <= if_inst;
      end
   end

   assign id_valid = idValid_q;
   assign id_pc    = idPc_q;
   assign id_inst  = idInst_q;
   assign count    = count_q;

endmodule

// File: doc/if_id_fifo.md
Name: if_id_fifo

Overview:
- Parametrised successor of the single-entry IF/ID pipeline register.
- A DEPTH-entry instruction queue sits between IF and ID, followed by a registered ID-side output stage.
- IF can keep fetching while ID is stalled, up to DEPTH entries. A pipeline flush clears the queue and the output stage.
- Adds valid tagging, IF backpressure (if_ready) and an occupancy count.

Parameters:
- ADDR_W, 32, width of PC.
- INST_W, 32, width of instruction word.
- DEPTH, 4, queue entries; power of two, minimum 2.
- CNT_W, $clog2(DEPTH+1), width of occupancy count.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  6  pipeline stall vector; 1 = Stop. Bit 1 = IF stalled, bit 2 = ID stalled.
- flush  in  1  synchronous pipeline flush (exception/redirect).
- if_valid  in  1  IF presents a fetched instruction.
- if_pc  in  ADDR_W  PC of the fetched instruction.
- if_inst  in  INST_W  fetched instruction word.
- if_ready  out  1  queue can accept; combinational, (count < DEPTH) && !flush.
- id_valid  out  1  id_pc/id_inst hold a real instruction; 0 = bubble.
- id_pc  out  ADDR_W  PC to ID.
- id_inst  out  INST_W  instruction to ID.
- count  out  CNT_W  entries currently queued; excludes the output stage.

Behaviour:
- Reset (async, rst=1):
  - count=0; read and write pointers 0.
  - id_valid=0; id_pc=0; id_inst=0.
  - Queue storage contents are don't-care.
  - Takes effect immediately and overrides any in-flight push or pop.
- push = if_valid && !stall[1] && if_ready.
- advance = !stall[2].
- Flush (clk edge, flush=1, rst=0):
  - count=0; pointers=0; id_valid=0; id_pc=0; id_inst=0.
  - Any push that cycle is dropped.
  - Flush has priority over push, advance and stall.
- Output stage, when advance=1 (no flush):
  - count>0: load the head entry into id_pc/id_inst, set id_valid=1, pop the head.
  - count=0 and push=1: bypass, loading if_pc/if_inst directly with id_valid=1. The queue is not written. IF→ID latency is 1 cycle, identical to the old register.
  - count=0 and push=0: load a bubble (id_valid=0, id_pc=0, id_inst=0).
- Output stage, when advance=0: id_* hold their values. A push writes the tail entry.
- Simultaneous push and pop with count>0: the tail is written and the head is read, so count is unchanged. Ordering is strict FIFO; the bypass is used only when the queue is empty.
- Full (count=DEPTH): if_ready=0, so no push. The same-cycle pop does not free a slot for a push until the next cycle; there is no full-bypass.
- stall[1]=1 && stall[2]=0: behaves as an advance with no push. An empty queue yields a bubble, preserving the old NOP-insertion semantics.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- count is updated as +1 on push-without-pop and -1 on pop-without-push. It never exceeds DEPTH and never underflows.
- if_valid=0 is never enqueued, whatever the stall state.

Test Plan:
- Reset mid-operation: fill 3 entries, assert rst between clock edges → count=0, id_valid=0, id_pc=0, id_inst=0 immediately; no clock edge required.
- Bypass latency: empty queue, stall=0, if_valid=1, if_pc=0x100, if_inst=0x24010005 → next edge id_valid=1, id_pc=0x100, id_inst=0x24010005, count stays 0.
- Fill to full: stall[2]=1, push PCs 0x0,0x4,0x8,0xC → count=4, if_ready=0. A 5th if_valid=1 is ignored. Release stall[2] → id_pc shows 0x0,0x4,0x8,0xC on 4 successive edges, then a bubble (id_valid=0, id_pc=0).
- Simultaneous push/pop with wrap: hold count=2 and stream 10 instructions with stall=0 → count stays 2. Output PC order exactly matches input order across pointer wrap.
- Flush priority: count=3, stall[2]=1, flush=1 and if_valid=1 on the same edge → count=0, id_valid=0, id_pc=0, if_ready=0 during flush. The new instruction is not enqueued.
- Legacy bubble: stall[1]=1, stall[2]=0, empty queue, if_valid=1 → id_valid=0, id_pc=0, id_inst=0, nothing enqueued.
